// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG register chain: TAP state codes,
// instruction opcodes and the default IDCODE value.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR        = 4'h0,
    RTI        = 4'h1,
    SELECT_DR  = 4'h2,
    CAPTURE_DR = 4'h3,
    SHIFT_DR   = 4'h4,
    EXIT1_DR   = 4'h5,
    PAUSE_DR   = 4'h6,
    EXIT2_DR   = 4'h7,
    UPDATE_DR  = 4'h8,
    SELECT_IR  = 4'h9,
    CAPTURE_IR = 4'hA,
    SHIFT_IR   = 4'hB,
    EXIT1_IR   = 4'hC,
    PAUSE_IR   = 4'hD,
    EXIT2_IR   = 4'hE,
    UPDATE_IR  = 4'hF
  } tap_state_e;

  localparam int IR_W = 4;

  localparam logic [IR_W-1:0] OP_IDCODE     = 4'h1;
  localparam logic [IR_W-1:0] OP_DBG_ADDR   = 4'h8;
  localparam logic [IR_W-1:0] OP_DBG_DATA   = 4'h9;
  localparam logic [IR_W-1:0] OP_DBG_STATUS = 4'hA;
  localparam logic [IR_W-1:0] OP_BYPASS     = 4'hF;

  localparam logic [31:0] IDCODE_DEFAULT = 32'h1000_0001;

endpackage

// File: rtl/jtag_shift_reg.sv
// One JTAG shift register: parallel capture, LSB-first shift with TDI
// entering the MSB, and an update enable gated by the register select.
// W must be at least 2; single-bit registers live in the top.
module jtag_shift_reg #(
  parameter int W = 2
) (
  input  logic         TCK,
  input  logic         TRST,
  input  logic         sel,
  input  logic         capture,
  input  logic         shift,
  input  logic         update,
  input  logic         tdi,
  input  logic [W-1:0] cap_val,
  output logic [W-1:0] sr,
  output logic         upd_en
);

  // Capture has priority over shift; an unselected register holds.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      sr <= '0;
    else if (sel && capture)
      sr <= cap_val;
    else if (sel && shift)
      sr <= {tdi, sr[W-1:1]};
  end

  assign upd_en = sel & update;

endmodule

// File: rtl/jtag_reg_chain.sv
// IR and DR chain downstream of the TAP controller, with the debug
// address/data write handshake towards the SchoolMIPS debug logic.
module jtag_reg_chain #(
  parameter int          IR_W       = jtag_pkg::IR_W,
  parameter int          ADDR_W     = 8,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] IDCODE_VAL = jtag_pkg::IDCODE_DEFAULT
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TDI,
  input  logic [3:0]        state_in,
  input  logic              sel_tdo,
  output logic              TDO,
  output logic              tdo_en,
  output logic [IR_W-1:0]   ir_out,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_wr_req,
  input  logic              dbg_wr_ack,
  input  logic [DATA_W-1:0] dbg_rdata
);
  import jtag_pkg::*;

  logic tlr, cap_ir, shf_ir, upd_ir, cap_dr, shf_dr, upd_dr;
  assign tlr    = (state_in == TLR);
  assign cap_ir = (state_in == CAPTURE_IR);
  assign shf_ir = (state_in == SHIFT_IR);
  assign upd_ir = (state_in == UPDATE_IR);
  assign cap_dr = (state_in == CAPTURE_DR);
  assign shf_dr = (state_in == SHIFT_DR);
  assign upd_dr = (state_in == UPDATE_DR);

  logic [IR_W-1:0] ir;
  assign ir_out = ir;

  // Undefined opcodes fall through to bypass.
  logic sel_idcode, sel_addr, sel_data, sel_status, sel_bypass;
  assign sel_idcode = (ir == IR_W'(OP_IDCODE));
  assign sel_addr   = (ir == IR_W'(OP_DBG_ADDR));
  assign sel_data   = (ir == IR_W'(OP_DBG_DATA));
  assign sel_status = (ir == IR_W'(OP_DBG_STATUS));
  assign sel_bypass = ~(sel_idcode | sel_addr | sel_data | sel_status);

  logic overrun;
  logic [IR_W-1:0]   ir_sr;
  logic [31:0]       idcode_sr;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;
  logic [1:0]        status_sr;
  logic ir_upd, idcode_upd, addr_upd, data_upd, status_upd;
  logic bypass_ff;

  jtag_shift_reg #(.W(IR_W)) u_ir (
    .TCK(TCK), .TRST(TRST), .sel(1'b1), .capture(cap_ir), .shift(shf_ir),
    .update(upd_ir), .tdi(TDI), .cap_val(IR_W'(2'b01)),
    .sr(ir_sr), .upd_en(ir_upd)
  );

  jtag_shift_reg #(.W(32)) u_idcode (
    .TCK(TCK), .TRST(TRST), .sel(sel_idcode), .capture(cap_dr), .shift(shf_dr),
    .update(upd_dr), .tdi(TDI), .cap_val(IDCODE_VAL),
    .sr(idcode_sr), .upd_en(idcode_upd)
  );

  jtag_shift_reg #(.W(ADDR_W)) u_addr (
    .TCK(TCK), .TRST(TRST), .sel(sel_addr), .capture(cap_dr), .shift(shf_dr),
    .update(upd_dr), .tdi(TDI), .cap_val(dbg_addr),
    .sr(addr_sr), .upd_en(addr_upd)
  );

  jtag_shift_reg #(.W(DATA_W)) u_data (
    .TCK(TCK), .TRST(TRST), .sel(sel_data), .capture(cap_dr), .shift(shf_dr),
    .update(upd_dr), .tdi(TDI), .cap_val(dbg_rdata),
    .sr(data_sr), .upd_en(data_upd)
  );

  jtag_shift_reg #(.W(2)) u_status (
    .TCK(TCK), .TRST(TRST), .sel(sel_status), .capture(cap_dr), .shift(shf_dr),
    .update(upd_dr), .tdi(TDI), .cap_val({overrun, dbg_wr_req}),
    .sr(status_sr), .upd_en(status_upd)
  );

  // IDCODE and STATUS are read-only; only their LSB reaches TDO.
  logic unused_bits;
  assign unused_bits = ^{idcode_upd, status_upd, idcode_sr[31:1], status_sr[1]};

  // Single-flop bypass register.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      bypass_ff <= 1'b0;
    else if (sel_bypass && cap_dr)
      bypass_ff <= 1'b0;
    else if (sel_bypass && shf_dr)
      bypass_ff <= TDI;
  end

  // Instruction register: forced to IDCODE in TLR, loaded on UPDATE_IR.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST)
      ir <= IR_W'(OP_IDCODE);
    else if (tlr)
      ir <= IR_W'(OP_IDCODE);
    else if (ir_upd)
      ir <= ir_sr;
  end

  // A completing request (ack this cycle) frees the slot for a new write.
  logic slot_free;
  assign slot_free = ~dbg_wr_req | dbg_wr_ack;

  // Write handshake, address update and sticky overrun (cleared by STATUS capture).
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      dbg_addr   <= '0;
      dbg_wdata  <= '0;
      dbg_wr_req <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (dbg_wr_req && dbg_wr_ack)
        dbg_wr_req <= 1'b0;
      if (sel_status && cap_dr)
        overrun <= 1'b0;
      if (data_upd) begin
        if (slot_free) begin
          dbg_wdata  <= data_sr;
          dbg_wr_req <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (addr_upd) begin
        if (slot_free)
          dbg_addr <= addr_sr;
        else
          overrun <= 1'b1;
      end
    end
  end

  // LSB of the currently selected data register.
  logic dr_lsb;
  always_comb begin
    dr_lsb = bypass_ff;
    if (sel_idcode)      dr_lsb = idcode_sr[0];
    else if (sel_addr)   dr_lsb = addr_sr[0];
    else if (sel_data)   dr_lsb = data_sr[0];
    else if (sel_status) dr_lsb = status_sr[0];
  end

  // TDO changes on the falling edge and holds outside the shift states.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      TDO    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= shf_ir | shf_dr;
      if (shf_ir | shf_dr)
        TDO <= sel_tdo ? ir_sr[0] : dr_lsb;
    end
  end

endmodule

// File: tb/tb_jtag_reg_chain.sv
// Directed bench for jtag_reg_chain: scans IR/DR through TAP state codes
// and checks TDO streams and the debug write handshake.
module tb_jtag_reg_chain;
  import jtag_pkg::*;

  logic        TCK = 1'b0;
  logic        TRST;
  logic        TDI;
  logic [3:0]  state_in;
  logic        sel_tdo;
  logic        TDO;
  logic        tdo_en;
  logic [3:0]  ir_out;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_wr_req;
  logic        dbg_wr_ack;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_fails  = 0;
  logic s_tdo, s_en;

  jtag_reg_chain dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .state_in(state_in), .sel_tdo(sel_tdo),
    .TDO(TDO), .tdo_en(tdo_en), .ir_out(ir_out), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_wr_req(dbg_wr_req), .dbg_wr_ack(dbg_wr_ack),
    .dbg_rdata(dbg_rdata)
  );

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCK cycle in state st; TDO/tdo_en are sampled after the falling edge.
  task automatic step(input logic [3:0] st, input logic tdi);
    state_in = st;
    TDI      = tdi;
    @(negedge TCK); #1;
    s_tdo = TDO;
    s_en  = tdo_en;
    @(posedge TCK); #1;
  endtask

  task automatic load_ir(input logic [3:0] v, output logic [3:0] dout);
    sel_tdo = 1'b1;
    dout = '0;
    step(CAPTURE_IR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(SHIFT_IR, v[i]);
      dout[i] = s_tdo;
    end
    step(EXIT1_IR, 1'b0);
    step(UPDATE_IR, 1'b0);
    sel_tdo = 1'b0;
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, input logic ack_upd,
                         output logic [31:0] dout, output int en_cnt);
    sel_tdo = 1'b0;
    dout = '0;
    en_cnt = 0;
    step(CAPTURE_DR, 1'b0);
    if (s_en) en_cnt++;
    for (int i = 0; i < n; i++) begin
      step(SHIFT_DR, din[i]);
      dout[i] = s_tdo;
      if (s_en) en_cnt++;
    end
    step(EXIT1_DR, 1'b0);
    if (s_en) en_cnt++;
    dbg_wr_ack = ack_upd;
    step(UPDATE_DR, 1'b0);
    dbg_wr_ack = 1'b0;
  endtask

  logic [3:0]  d4;
  logic [31:0] d;
  logic [4:0]  bp_in, bp_out;
  int          en;

  initial begin
    TRST = 1'b1; state_in = TLR; TDI = 1'b0; sel_tdo = 1'b0;
    dbg_wr_ack = 1'b0; dbg_rdata = 32'h1234_5678;
    repeat (2) @(posedge TCK);
    #1;
    check("rst_ir",     ir_out,     32'h1);
    check("rst_addr",   dbg_addr,   32'h0);
    check("rst_wdata",  dbg_wdata,  32'h0);
    check("rst_req",    dbg_wr_req, 32'h0);
    check("rst_tdo",    TDO,        32'h0);
    check("rst_tdo_en", tdo_en,     32'h0);
    TRST = 1'b0;

    step(TLR, 1'b0);
    step(RTI, 1'b0);
    dr_scan(32, 32'h0, 1'b0, d, en);
    check("idcode_stream", d, 32'h1000_0001);
    check("idcode_en_cnt", en, 32);

    load_ir(4'h9, d4);
    check("ir_capture", d4, 32'h1);
    check("ir_data", ir_out, 32'h9);

    dr_scan(32, 32'hDEAD_BEEF, 1'b0, d, en);
    check("rdata_capture", d, 32'h1234_5678);
    check("req_set", dbg_wr_req, 32'h1);
    check("wdata_set", dbg_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      step(RTI, 1'b0);
      check("req_hold", dbg_wr_req, 32'h1);
    end
    dbg_wr_ack = 1'b1;
    step(RTI, 1'b0);
    dbg_wr_ack = 1'b0;
    check("req_ack", dbg_wr_req, 32'h0);

    load_ir(4'h8, d4);
    dr_scan(8, 32'hA5, 1'b0, d, en);
    check("addr_cap0", d, 32'h0);
    check("addr_upd0", dbg_addr, 32'hA5);
    dr_scan(8, 32'h3C, 1'b0, d, en);
    check("addr_cap1", d, 32'hA5);
    check("addr_upd1", dbg_addr, 32'h3C);

    load_ir(4'h9, d4);
    dr_scan(32, 32'hCAFE_F00D, 1'b0, d, en);
    check("req_set2", dbg_wr_req, 32'h1);
    dr_scan(32, 32'h1111_1111, 1'b0, d, en);
    check("wdata_kept", dbg_wdata, 32'hCAFE_F00D);
    check("req_kept", dbg_wr_req, 32'h1);
    load_ir(4'h8, d4);
    dr_scan(8, 32'h77, 1'b0, d, en);
    check("addr_blocked", dbg_addr, 32'h3C);
    load_ir(4'hA, d4);
    dr_scan(2, 32'h0, 1'b0, d, en);
    check("status_ovr", d, 32'h3);
    dr_scan(2, 32'h0, 1'b0, d, en);
    check("status_clr", d, 32'h1);

    load_ir(4'h9, d4);
    dr_scan(32, 32'h0BAD_F00D, 1'b1, d, en);
    check("ack_same_req", dbg_wr_req, 32'h1);
    check("ack_same_wdata", dbg_wdata, 32'h0BAD_F00D);
    load_ir(4'hA, d4);
    dr_scan(2, 32'h0, 1'b0, d, en);
    check("ack_same_status", d, 32'h1);
    dbg_wr_ack = 1'b1;
    step(RTI, 1'b0);
    dbg_wr_ack = 1'b0;
    check("req_ack2", dbg_wr_req, 32'h0);

    load_ir(4'h3, d4);
    check("ir_undef", ir_out, 32'h3);
    bp_in = 5'b01101;
    bp_out = '0;
    step(CAPTURE_DR, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(SHIFT_DR, bp_in[i]);
      bp_out[i] = s_tdo;
    end
    check("bypass_stream", bp_out, 32'h1A);
    step(EXIT1_DR, 1'b0);
    check("tdo_en_off", s_en, 32'h0);
    step(TLR, 1'b0);
    check("tlr_ir", ir_out, 32'h1);

    step(RTI, 1'b0);
    load_ir(4'h9, d4);
    dr_scan(32, 32'hFEED_FACE, 1'b0, d, en);
    check("req_set3", dbg_wr_req, 32'h1);
    step(CAPTURE_DR, 1'b0);
    step(SHIFT_DR, 1'b1);
    step(SHIFT_DR, 1'b0);
    #2 TRST = 1'b1;
    #1;
    check("mid_rst_req", dbg_wr_req, 32'h0);
    check("mid_rst_ir", ir_out, 32'h1);
    check("mid_rst_addr", dbg_addr, 32'h0);
    check("mid_rst_wdata", dbg_wdata, 32'h0);
    @(posedge TCK); #1;
    TRST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/jtag_reg_chain.md
Name: jtag_reg_chain

Overview:
- Instruction register plus data-register chain that sits directly downstream of the TAP controller.
- Decodes the TAP state code to perform capture, shift and update on IR and on the selected DR.
- Drives TDO.
- Exposes a debug address/data port with a req/ack write handshake towards the SchoolMIPS debug logic.
- Single clock domain (TCK).

Parameters:
- IR_W, 4, instruction register width.
- ADDR_W, 8, debug address register width.
- DATA_W, 32, debug data register width.
- IDCODE_VAL, 32'h1000_0001, value captured by IDCODE; bit 0 must be 1.

Ports:
- TCK  in  1  JTAG clock; all logic on posedge except TDO, which is on negedge.
- TRST  in  1  asynchronous, active-high reset.
- TDI  in  1  serial data in.
- state_in  in  4  TAP state code from the TAP controller (TLR=0 … UPDATE_IR=F).
- sel_tdo  in  1  from the TAP controller; 1 selects IR onto TDO, 0 selects DR.
- TDO  out  1  serial data out.
- tdo_en  out  1  high while shifting.
- ir_out  out  IR_W  current (updated) instruction.
- dbg_addr  out  ADDR_W  debug address register.
- dbg_wdata  out  DATA_W  write data, valid while dbg_wr_req is high.
- dbg_wr_req  out  1  write request; held until acknowledged.
- dbg_wr_ack  in  1  one-cycle acknowledge.
- dbg_rdata  in  DATA_W  read data for dbg_addr, sampled at CAPTURE_DR.

Behaviour:
- Reset (TRST=1, async): ir=IDCODE, ir_sr=0, all DR shift registers=0, dbg_addr=0, dbg_wdata=0, dbg_wr_req=0, overrun=0, TDO=0, tdo_en=0.
- State TLR (0), sampled at posedge: ir<=IDCODE. Does not touch dbg_addr or the handshake.

Instructions:
- IDCODE=1, DBG_ADDR=8, DBG_DATA=9, DBG_STATUS=A, BYPASS=F.
- Any other code selects BYPASS.

IR path:
- CAPTURE_IR: ir_sr<={0…,2'b01}.
- SHIFT_IR: ir_sr<={TDI, ir_sr[IR_W-1:1]} (LSB first).
- UPDATE_IR: ir<=ir_sr.

DR path (selected by current ir only):
- CAPTURE_DR loads the selected register:
  - IDCODE: IDCODE_VAL.
  - BYPASS: 0.
  - DBG_ADDR: dbg_addr.
  - DBG_DATA: dbg_rdata.
  - DBG_STATUS: {overrun, dbg_wr_req}, 2 bits. overrun clears in the same cycle (read-to-clear).
- SHIFT_DR: right-shift the selected register with TDI into its MSB. Unselected registers hold.
- UPDATE_DR:
  - DBG_ADDR: dbg_addr<=sr.
  - DBG_DATA: see write handshake below.
  - Other instructions: no effect.

Write handshake:
- UPDATE_DR with DBG_DATA while the slot is free: dbg_wdata<=sr and dbg_wr_req<=1, visible the next cycle.
- The slot is free when dbg_wr_req=0, or when dbg_wr_ack=1 in the same cycle (ack has priority).
- The request holds, with dbg_wdata and dbg_addr stable, until dbg_wr_ack; dbg_wr_req then falls the next cycle.
- UPDATE_DR with DBG_DATA while the slot is busy: data is dropped and overrun<=1 (sticky).
- dbg_wr_ack while dbg_wr_req=0 is ignored.
- UPDATE_DR DBG_ADDR while a request is pending: dbg_addr is not updated, and overrun<=1.

TDO (negedge TCK):
- TDO<=sel_tdo ? ir_sr[0] : selected_dr_sr[0].
- tdo_en<=(state_in==SHIFT_IR)|(state_in==SHIFT_DR).
- Outside shift states TDO holds its last value.

Reset mid-transfer: everything returns to reset values and any pending request is abandoned.

Decomposition:
- Package jtag_pkg contains:
  - 4-bit TAP state codes (shared with the TAP controller).
  - IR_W and the instruction opcodes.
  - Default IDCODE_VAL.
- One natural sub-module, jtag_shift_reg (parameter W): capture, shift and update-enable for a single register.
  - Instantiated for the IR, IDCODE, ADDR, DATA and STATUS registers.
  - BYPASS is a single flop inside the top.

Test Plan:
- TRST pulse, then CAPTURE_DR+32×SHIFT_DR from TLR → TDO stream LSB-first = 32'h1000_0001; tdo_en high for exactly 32 shift cycles.
- Shift IR=4'h9 → captured IR shifts out 4'b0001. Next, DBG_DATA shift of 32'hDEAD_BEEF followed by UPDATE_DR → dbg_wr_req=1 next cycle with dbg_wdata=DEADBEEF; ack held off 5 cycles → req stays high; ack → req=0 the following cycle.
- Second DATA update while req is pending → dbg_wdata unchanged; STATUS capture shifts out 2'b11; a second STATUS capture shifts out 2'b01 (overrun cleared).
- UPDATE_DR DBG_DATA in the same cycle as dbg_wr_ack → new data accepted, req stays 1, overrun=0.
- IR=4'h3 (undefined) → DR chain behaves as 1-bit bypass: TDI pattern 1011 appears on TDO delayed by one shift.
- TRST asserted mid SHIFT_DR with req pending → req=0, ir=IDCODE, dbg_addr=0 immediately.
